// File: rtl/demux2_stream.sv
// Two-way stream demultiplexer: each input word is steered by S into one of two
// independent one-entry output registers, each with its own delivered-word counter.
module demux2_stream #(
  parameter int width     = 32,
  parameter int cnt_width = 16
) (
  input  logic                 CLK,
  input  logic                 ASYNCRESETN,
  input  logic [width-1:0]     I,
  input  logic                 S,
  input  logic                 I_valid,
  output logic                 I_ready,
  output logic [width-1:0]     O0,
  output logic                 O0_valid,
  input  logic                 O0_ready,
  output logic [cnt_width-1:0] O0_count,
  output logic [width-1:0]     O1,
  output logic                 O1_valid,
  input  logic                 O1_ready,
  output logic [cnt_width-1:0] O1_count
);

  // Handshake: a word moves on any port in a cycle where valid && ready at the
  // rising edge; a producer holds data stable while valid && !ready, and ready
  // may depend combinationally on the consumer side but never on valid.

  logic [1:0]           v_q, v_d;
  logic [width-1:0]     d_q [2];
  logic [width-1:0]     d_d [2];
  logic [cnt_width-1:0] c_q [2];
  logic [cnt_width-1:0] c_d [2];
  logic [1:0]           rdy;
  logic [1:0]           free;

  always_comb begin
    rdy     = {O1_ready, O0_ready};
    free    = ~v_q | rdy;
    // Only the selected branch gates acceptance, so a stalled branch cannot block the other.
    I_ready = free[S];
    v_d     = v_q;
    d_d     = d_q;
    c_d     = c_q;
    for (int k = 0; k < 2; k++) begin
      if (v_q[k] && rdy[k]) begin
        v_d[k] = 1'b0;
        c_d[k] = c_q[k] + 1'b1;
      end
      // A load after a drain in the same cycle keeps the branch valid with the new word.
      if (I_valid && I_ready && (S == 1'(k))) begin
        v_d[k] = 1'b1;
        d_d[k] = I;
      end
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      v_q <= '0;
      d_q <= '{default: '0};
      c_q <= '{default: '0};
    end else begin
      v_q <= v_d;
      d_q <= d_d;
      c_q <= c_d;
    end
  end

  assign O0       = d_q[0];
  assign O1       = d_q[1];
  assign O0_valid = v_q[0];
  assign O1_valid = v_q[1];
  assign O0_count = c_q[0];
  assign O1_count = c_q[1];

endmodule

// File: tb/tb_demux2_stream.sv
// Bench for demux2_stream: table vectors, hand-written corner sequences and random
// traffic, all checked against a per-branch queue model of pending words.
module tb_demux2_stream;

  logic        CLK;
  logic        ASYNCRESETN;
  logic [31:0] I;
  logic        S;
  logic        I_valid;
  logic        I_ready;
  logic [31:0] O0, O1;
  logic        O0_valid, O1_valid;
  logic        O0_ready, O1_ready;
  logic [15:0] O0_count, O1_count;

  logic        s_I_ready;
  logic [31:0] s_O0, s_O1;
  logic        s_O0_valid, s_O1_valid;
  logic [3:0]  s_O0_count, s_O1_count;

  demux2_stream #(.width(32), .cnt_width(16)) dut (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .I(I), .S(S), .I_valid(I_valid),
    .I_ready(I_ready), .O0(O0), .O0_valid(O0_valid), .O0_ready(O0_ready),
    .O0_count(O0_count), .O1(O1), .O1_valid(O1_valid), .O1_ready(O1_ready),
    .O1_count(O1_count)
  );

  // Narrow-counter copy on the same stimulus, used for counter wrap.
  demux2_stream #(.width(32), .cnt_width(4)) dut_small (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .I(I), .S(S), .I_valid(I_valid),
    .I_ready(s_I_ready), .O0(s_O0), .O0_valid(s_O0_valid), .O0_ready(O0_ready),
    .O0_count(s_O0_count), .O1(s_O1), .O1_valid(s_O1_valid), .O1_ready(O1_ready),
    .O1_count(s_O1_count)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;

  // scoreboard / reference model: words accepted but not yet delivered
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [31:0] last0, last1;
  int          cnt0, cnt1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void model_clear();
    exp_q0.delete();
    exp_q1.delete();
    last0 = '0;
    last1 = '0;
    cnt0  = 0;
    cnt1  = 0;
  endfunction

  // One clock cycle: called just after a falling edge, returns just after the next one.
  task automatic step(input logic [31:0] i, input logic s, input logic iv,
                      input logic r0, input logic r1, output logic irdy);
    logic e_rdy;
    I = i; S = s; I_valid = iv; O0_ready = r0; O1_ready = r1;
    #1;
    irdy = I_ready;
    check("o0_valid", 64'(O0_valid), 64'(exp_q0.size() > 0));
    check("o1_valid", 64'(O1_valid), 64'(exp_q1.size() > 0));
    check("o0_data", 64'(O0), 64'(last0));
    check("o1_data", 64'(O1), 64'(last1));
    check("o0_count", 64'(O0_count), 64'(cnt0 % 65536));
    check("o1_count", 64'(O1_count), 64'(cnt1 % 65536));
    check("small_o0_count", 64'(s_O0_count), 64'(cnt0 % 16));
    check("small_o1_count", 64'(s_O1_count), 64'(cnt1 % 16));
    e_rdy = s ? (exp_q1.size() == 0 || r1) : (exp_q0.size() == 0 || r0);
    check("i_ready", 64'(I_ready), 64'(e_rdy));
    if (exp_q0.size() > 0 && r0) begin
      check("deliver0", 64'(O0), 64'(exp_q0[0]));
      void'(exp_q0.pop_front());
      cnt0++;
    end
    if (exp_q1.size() > 0 && r1) begin
      check("deliver1", 64'(O1), 64'(exp_q1[0]));
      void'(exp_q1.pop_front());
      cnt1++;
    end
    if (iv && e_rdy) begin
      if (s) begin exp_q1.push_back(i); last1 = i; end
      else   begin exp_q0.push_back(i); last0 = i; end
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Asserts reset between clock edges and checks it takes effect with no edge.
  task automatic do_reset();
    I_valid = 1'b0; O0_ready = 1'b0; O1_ready = 1'b0; S = 1'b0;
    #2;
    ASYNCRESETN = 1'b0;
    model_clear();
    #1;
    check("rst_o0_valid", 64'(O0_valid), 64'd0);
    check("rst_o1_valid", 64'(O1_valid), 64'd0);
    check("rst_o0", 64'(O0), 64'd0);
    check("rst_o1", 64'(O1), 64'd0);
    check("rst_o0_count", 64'(O0_count), 64'd0);
    check("rst_o1_count", 64'(O1_count), 64'd0);
    check("rst_i_ready", 64'(I_ready), 64'd1);
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
  endtask

  typedef struct {
    logic [31:0] i;
    logic        s;
    logic        iv;
    logic        r0;
    logic        r1;
    logic        e_rdy;
    logic        e_v0;
    logic        e_v1;
  } vec_t;

  vec_t alt_tbl[5];
  vec_t stall_tbl[5];

  initial begin
    logic irdy;
    alt_tbl[0] = '{32'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    alt_tbl[1] = '{32'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    alt_tbl[2] = '{32'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    alt_tbl[3] = '{32'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    alt_tbl[4] = '{32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    stall_tbl[0] = '{32'h11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    stall_tbl[1] = '{32'h22, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    stall_tbl[2] = '{32'h33, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    stall_tbl[3] = '{32'h22, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    stall_tbl[4] = '{32'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    ASYNCRESETN = 1'b0;
    I = '0; S = 1'b0; I_valid = 1'b0; O0_ready = 1'b0; O1_ready = 1'b0;
    model_clear();
    @(negedge CLK);
    do_reset();

    // single word to branch 0
    step(32'hA5A5A5A5, 1'b0, 1'b1, 1'b1, 1'b1, irdy);
    #1;
    check("first_o0", 64'(O0), 64'hA5A5A5A5);
    check("first_o0_valid", 64'(O0_valid), 64'd1);
    check("first_o1_valid", 64'(O1_valid), 64'd0);
    step(32'h0, 1'b0, 1'b0, 1'b1, 1'b1, irdy);
    #1;
    check("first_o0_count", 64'(O0_count), 64'd1);

    // alternating select
    do_reset();
    foreach (alt_tbl[n]) begin
      step(alt_tbl[n].i, alt_tbl[n].s, alt_tbl[n].iv, alt_tbl[n].r0, alt_tbl[n].r1, irdy);
      check("alt_i_ready", 64'(irdy), 64'(alt_tbl[n].e_rdy));
      #1;
      check("alt_v0", 64'(O0_valid), 64'(alt_tbl[n].e_v0));
      check("alt_v1", 64'(O1_valid), 64'(alt_tbl[n].e_v1));
    end
    check("alt_count0", 64'(O0_count), 64'd2);
    check("alt_count1", 64'(O1_count), 64'd2);

    // branch 1 stall does not block branch 0
    do_reset();
    foreach (stall_tbl[n]) begin
      step(stall_tbl[n].i, stall_tbl[n].s, stall_tbl[n].iv, stall_tbl[n].r0, stall_tbl[n].r1, irdy);
      check("stall_i_ready", 64'(irdy), 64'(stall_tbl[n].e_rdy));
      #1;
      check("stall_v0", 64'(O0_valid), 64'(stall_tbl[n].e_v0));
      check("stall_v1", 64'(O1_valid), 64'(stall_tbl[n].e_v1));
      if (n == 1 || n == 2) check("stall_o1_hold", 64'(O1), 64'h11);
      if (n == 2) check("stall_o0", 64'(O0), 64'h33);
      if (n == 3) check("stall_o1_next", 64'(O1), 64'h22);
    end
    check("stall_count1", 64'(O1_count), 64'd2);

    // back-to-back stream on branch 0
    do_reset();
    for (int j = 0; j < 8; j++) begin
      step(32'h100 + 32'(j), 1'b0, 1'b1, 1'b1, 1'b0, irdy);
      #1;
      check("stream_v0", 64'(O0_valid), 64'd1);
    end
    step(32'h0, 1'b0, 1'b0, 1'b1, 1'b0, irdy);
    #1;
    check("stream_count0", 64'(O0_count), 64'd8);

    // narrow counter wraps after 17 deliveries
    do_reset();
    for (int j = 0; j < 17; j++) step(32'h200 + 32'(j), 1'b0, 1'b1, 1'b1, 1'b0, irdy);
    step(32'h0, 1'b0, 1'b0, 1'b1, 1'b0, irdy);
    #1;
    check("wrap_small_count0", 64'(s_O0_count), 64'd1);
    check("wrap_count0", 64'(O0_count), 64'd17);

    // random traffic
    do_reset();
    for (int j = 0; j < 400; j++) begin
      step($urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, irdy);
    end

    // reset mid-operation with a buffered word on branch 1
    do_reset();
    for (int j = 0; j < 5; j++) step(32'h300 + 32'(j), 1'b1, 1'b1, 1'b0, 1'b1, irdy);
    step(32'h0, 1'b1, 1'b0, 1'b0, 1'b1, irdy);
    step(32'h77, 1'b1, 1'b1, 1'b0, 1'b0, irdy);
    #1;
    check("pre_rst_o1_valid", 64'(O1_valid), 64'd1);
    check("pre_rst_o1_count", 64'(O1_count), 64'd5);
    do_reset();
    for (int j = 0; j < 4; j++) step(32'h0, 1'b1, 1'b0, 1'b1, 1'b1, irdy);
    #1;
    check("post_rst_o1_valid", 64'(O1_valid), 64'd0);
    check("post_rst_o1_count", 64'(O1_count), 64'd0);

    // final report
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/demux2_stream.md
# demux2_stream

Two-way stream demultiplexer with registered outputs: one valid/ready input stream of `width`-bit words is steered to one of two output streams by a per-word select bit. It is the write/steer-side counterpart of the 2:1 read mux in the register-file datapath. It distributes incoming words to two consumers, such as the reg0/reg1 write ports. Each branch has its own one-entry output register and a transfer counter, so a stalled branch never blocks words bound for the other branch.

## Interface
- `width`, 32, data width of input and both outputs
- `cnt_width`, 16, width of each per-branch transfer counter
- `CLK`  input  1  single clock, all state on rising edge
- `ASYNCRESETN`  input  1  asynchronous, active-low reset
- `I`  input  width  input data word
- `S`  input  1  destination select, sampled with `I`: 0 selects O0, 1 selects O1
- `I_valid`  input  1  input word present
- `I_ready`  output  1  block accepts the input word this cycle
- `O0` / `O1`  output  width  branch data, register outputs
- `O0_valid` / `O1_valid`  output  1  branch word present, register outputs
- `O0_ready` / `O1_ready`  input  1  branch consumer accepts
- `O0_count` / `O1_count`  output  cnt_width  words delivered on the branch, register outputs

## Operation
- State per branch k:
  - valid flag `vk`
  - data register `dk`
  - counter `ck`
- Branch k is free when `!vk || Ok_ready`.
- `I_ready` is combinational and depends on `S`:
  - `S=0`: `I_ready` is branch 0 free.
  - `S=1`: `I_ready` is branch 1 free.
  - `I_ready` never depends on the unselected branch.
- An input transfer occurs when `I_valid && I_ready`:
  - the target branch k = `S` loads `dk <= I`
  - `vk <= 1`
- An output transfer on branch k occurs when `vk && Ok_ready`:
  - `ck <= ck + 1`, modulo 2^cnt_width, so the counter wraps from all-ones to 0
  - if branch k does not load an input word in the same cycle, `vk <= 0`
- Simultaneous drain and load on the same branch: the new word replaces the old one and `vk` stays 1. This gives full throughput of one word per cycle per branch.
- Branches are independent:
  - a load on one branch and a drain on the other may happen in the same cycle
  - both branches may drain in the same cycle
- While `vk=1 && !Ok_ready`:
  - `Ok` and `Ok_valid` hold stable
  - input words with `S=k` are stalled (`I_ready=0`)
  - input words with `S=!k` still flow if their branch is free
- `dk` changes only on a load of branch k. It is never cleared on drain.
- The block never drops or duplicates a word. Per branch, output order equals input order.
- `I_valid=0`: no load occurs, and `I_ready` still reflects the `S` branch.

## Timing
- Latency: a word accepted at edge n appears on `Ok` with `Ok_valid=1` after edge n (registered, 1 cycle).
- Throughput: 1 word/cycle aggregate when the selected consumer is ready.
- Reset (`ASYNCRESETN=0`), effective immediately with no clock:
  - `v0=v1=0`
  - `O0=O1=0`
  - `O0_count=O1_count=0`
  - `I_ready` follows from the free rule, so it is 1 during reset
- Reset asserted mid-operation discards any buffered words. Counts return to 0.
- Release of reset is clocked normally. The first load can occur at the first edge after deassertion.
- Counter increments are visible on the cycle after the drain edge.

## Test plan
- Reset, then send `I=0xA5A5A5A5`, `S=0`, `O0_ready=1` → the cycle after acceptance: `O0=0xA5A5A5A5`, `O0_valid=1`, `O1_valid=0`; the next cycle: `O0_count=1`.
- Alternate `S`=0,1,0,1 with words 1,2,3,4, both readies held 1 → O0 receives 1 then 3, O1 receives 2 then 4, `I_ready` stays 1 throughout, both counts end at 2.
- Hold `O1_ready=0`, send `0x11` with `S=1`, then `0x22` with `S=1`, then `0x33` with `S=0` → `O1` holds `0x11` stable, `I_ready=0` while `0x22` is presented, `0x33` reaches O0 the cycle after it is presented; releasing `O1_ready` delivers `0x11` then `0x22`.
- Continuous stream of 8 words on `S=0` with `O0_ready=1` → 8 words delivered back-to-back on O0, `v0` stays 1 between words, `O0_count=8`.
- Force `O0_count` near wrap (`cnt_width=4`), deliver 17 words on branch 0 → count reads 1.
- Assert `ASYNCRESETN=0` mid-cycle while `O1_valid=1` and `O1_count=5` → `O1_valid`, `O1` and `O1_count` go to 0 immediately without a clock edge, and no stale word appears after reset release.
